// File: rtl/spi_master_mc_if.sv
// Word-level handshake between a word source and spi_master_mc.
// The source offers tx words with valid/ready; received words come back as a one-cycle pulse.
interface spi_master_mc_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_last;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;

  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/spi_master_mc.sv
// Multi-chip-select SPI master with runtime CPOL/CPHA, programmable SCLK divider and
// bursts that hold chip select across words. All outputs are registered.
module spi_master_mc #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CS = 4,
  parameter int unsigned DIV_W  = 8,
  localparam int unsigned SelW  = $clog2(NUM_CS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [SelW-1:0]   cfg_cs_sel,
  spi_master_mc_if.slave    bus,
  output logic              busy,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam int unsigned TogW = $clog2(2 * DATA_W + 1);
  localparam logic [TogW-1:0] TogLast = TogW'(2 * DATA_W);

  typedef enum logic [2:0] {StIdle, StLead, StXfer, StWait, StTrail, StGap} state_e;

  state_e            state_q;
  logic              cpol_q;
  logic              cpha_q;
  logic              last_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [TogW-1:0]   tog_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              ready_q;
  logic              rx_valid_q;

  logic              tick;
  logic [TogW-1:0]   tog_nxt;
  logic              last_tog;
  logic              samp;
  logic              adv;

  // Out-of-range selects decode to all-ones so the transfer runs with no slave addressed.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [SelW-1:0] sel);
    logic [NUM_CS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == SelW'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  // tog_nxt is the number of the toggle that fires when the half-period counter expires.
  always_comb begin
    tick     = (cnt_q == div_q);
    tog_nxt  = tog_q + TogW'(1);
    last_tog = (tog_nxt == TogLast);
    samp     = cpha_q ? ~tog_nxt[0] : tog_nxt[0];
    adv      = cpha_q ? (tog_nxt[0] && (tog_nxt >= TogW'(3))) : (~tog_nxt[0] && !last_tog);
  end

  assign bus.tx_ready = ready_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      last_q     <= 1'b0;
      div_q      <= '0;
      cnt_q      <= '0;
      tog_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      ready_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      busy       <= 1'b0;
      spi_clk    <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_cs_n   <= '1;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          spi_clk <= cfg_cpol;
          ready_q <= 1'b1;
          if (bus.tx_valid && ready_q) begin
            cpol_q   <= cfg_cpol;
            cpha_q   <= cfg_cpha;
            div_q    <= cfg_div;
            spi_cs_n <= cs_decode(cfg_cs_sel);
            last_q   <= bus.tx_last;
            spi_mosi <= bus.tx_data[DATA_W-1];
            tx_sh_q  <= {bus.tx_data[DATA_W-2:0], 1'b0};
            cnt_q    <= '0;
            tog_q    <= '0;
            ready_q  <= 1'b0;
            busy     <= 1'b1;
            state_q  <= StLead;
          end
        end

        // LEAD is the half-period before toggle 1; both states share the toggle engine.
        StLead, StXfer: begin
          if (tick) begin
            cnt_q   <= '0;
            spi_clk <= ~spi_clk;
            tog_q   <= tog_nxt;
            if (samp) rx_sh_q <= {rx_sh_q[DATA_W-2:0], spi_miso};
            if (adv) begin
              spi_mosi <= tx_sh_q[DATA_W-1];
              tx_sh_q  <= tx_sh_q << 1;
            end
            if (last_tog) begin
              rx_valid_q <= 1'b1;
              // With CPHA=1 the final sample lands on this same edge.
              rx_data_q  <= cpha_q ? {rx_sh_q[DATA_W-2:0], spi_miso} : rx_sh_q;
              tog_q      <= '0;
              if (last_q) begin
                state_q <= StTrail;
              end else begin
                state_q <= StWait;
                ready_q <= 1'b1;
              end
            end else begin
              state_q <= StXfer;
            end
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end

        StWait: begin
          spi_clk <= cpol_q;
          if (bus.tx_valid) begin
            last_q   <= bus.tx_last;
            spi_mosi <= bus.tx_data[DATA_W-1];
            tx_sh_q  <= {bus.tx_data[DATA_W-2:0], 1'b0};
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            state_q  <= StLead;
          end
        end

        StTrail: begin
          spi_clk <= cpol_q;
          if (tick) begin
            cnt_q    <= '0;
            spi_cs_n <= '1;
            state_q  <= StGap;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end

        StGap: begin
          if (tick) begin
            cnt_q   <= '0;
            busy    <= 1'b0;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: an 8-bit/4-CS instance with a slave model or loopback,
// and a 16-bit/3-CS instance for the out-of-range chip-select case.
module tb_spi_master_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Instance 0: DATA_W=8, NUM_CS=4
  logic       rst0, cpol0, cpha0, clk0, mosi0, miso0, busy0;
  logic [7:0] div0;
  logic [1:0] sel0;
  logic [3:0] csn0;
  spi_master_mc_if #(.DATA_W(8)) b0 ();

  spi_master_mc #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) dut0 (
    .clk(clk), .rst(rst0), .cfg_cpol(cpol0), .cfg_cpha(cpha0), .cfg_div(div0),
    .cfg_cs_sel(sel0), .bus(b0), .busy(busy0), .spi_clk(clk0), .spi_mosi(mosi0),
    .spi_miso(miso0), .spi_cs_n(csn0)
  );

  // Instance 1: DATA_W=16, NUM_CS=3, MISO looped back
  logic        rst1, cpol1, cpha1, clk1, mosi1, busy1;
  logic [7:0]  div1;
  logic [1:0]  sel1;
  logic [2:0]  csn1;
  spi_master_mc_if #(.DATA_W(16)) b1 ();

  spi_master_mc #(.DATA_W(16), .NUM_CS(3), .DIV_W(8)) dut1 (
    .clk(clk), .rst(rst1), .cfg_cpol(cpol1), .cfg_cpha(cpha1), .cfg_div(div1),
    .cfg_cs_sel(sel1), .bus(b1), .busy(busy1), .spi_clk(clk1), .spi_mosi(mosi1),
    .spi_miso(mosi1), .spi_cs_n(csn1)
  );

  // Slave model for instance 0, returns sl_word in the mode given by s_cpha.
  bit         loop0 = 1'b1;
  bit         s_cpha = 1'b0;
  bit         burst_mon = 1'b0;
  logic [7:0] sl_word;
  logic [7:0] sl_rx = '0;
  logic       sl_miso = 1'b0;
  logic       pclk0, pmosi0, pclk1;
  bit         sl_act = 1'b0;
  int         sl_cnt = 0, sl_idx = 0;
  int         tog0 = 0, tog1 = 0, mosi_bad = 0, cs_glitch = 0, cs1_low = 0;
  int         rx_cnt0 = 0, rx_cnt1 = 0;
  logic [7:0]  q0[$];
  logic [15:0] q1[$];

  assign miso0 = loop0 ? mosi0 : sl_miso;

  always @(negedge clk) begin
    if (clk0 !== pclk0) tog0++;
    if (burst_mon && csn0 !== 4'b1101) cs_glitch++;
    if ((&csn0) !== 1'b0) begin
      sl_act = 1'b0;
    end else if (!sl_act) begin
      sl_act = 1'b1;
      sl_cnt = 0;
      sl_idx = 7;
      if (!s_cpha) begin
        sl_miso = sl_word[7];
        sl_idx  = 6;
      end
    end else if (clk0 !== pclk0) begin
      sl_cnt++;
      if ((sl_cnt % 2 == 1) != s_cpha) begin
        sl_rx = {sl_rx[6:0], mosi0};
        if (mosi0 !== pmosi0) mosi_bad++;
      end else if (sl_idx >= 0) begin
        sl_miso = sl_word[sl_idx];
        sl_idx--;
      end
    end
    pclk0  = clk0;
    pmosi0 = mosi0;
    if (clk1 !== pclk1) tog1++;
    if (csn1 !== 3'b111) cs1_low++;
    pclk1 = clk1;
  end

  // Scoreboard: pop the expected word on each rx_valid pulse.
  always @(negedge clk) begin
    if (b0.rx_valid === 1'b1) begin
      rx_cnt0++;
      chk("rx0_expected", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) chk("rx0_data", 32'(b0.rx_data), 32'(q0.pop_front()));
    end
    if (b1.rx_valid === 1'b1) begin
      rx_cnt1++;
      chk("rx1_expected", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) chk("rx1_data", 32'(b1.rx_data), 32'(q1.pop_front()));
    end
  end

  task automatic send0(input logic [7:0] d, input bit last, input logic [7:0] exp);
    int n = 0;
    b0.tx_data  = d;
    b0.tx_last  = last;
    b0.tx_valid = 1'b1;
    while (b0.tx_ready !== 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("tx0_ready_seen", 32'(b0.tx_ready), 1);
    q0.push_back(exp);
    cyc(1);
    b0.tx_valid = 1'b0;
  endtask

  task automatic wait_rx0(output int n);
    n = 0;
    while (b0.rx_valid !== 1'b1 && n < 2000) begin
      cyc(1);
      n++;
    end
    chk("rx0_seen", 32'(b0.rx_valid), 1);
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (!(b0.tx_ready === 1'b1 && busy0 === 1'b0) && n < 2000) begin
      cyc(1);
      n++;
    end
    chk("idle0_reached", 32'(busy0), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, rxb;
    logic [7:0] txw;
    sl_word = 8'h3C;
    rst0 = 1'b1; rst1 = 1'b1;
    cpol0 = 1'b0; cpha0 = 1'b0; div0 = '0; sel0 = 2'd1;
    cpol1 = 1'b0; cpha1 = 1'b0; div1 = '0; sel1 = 2'd3;
    b0.tx_valid = 1'b0; b0.tx_data = '0; b0.tx_last = 1'b0;
    b1.tx_valid = 1'b0; b1.tx_data = '0; b1.tx_last = 1'b0;
    cyc(3);

    // Reset state
    chk("rst_cs_n", 32'(csn0), 32'hF);
    chk("rst_sclk", 32'(clk0), 0);
    chk("rst_mosi", 32'(mosi0), 0);
    chk("rst_ready", 32'(b0.tx_ready), 0);
    chk("rst_rx_valid", 32'(b0.rx_valid), 0);
    chk("rst_rx_data", 32'(b0.rx_data), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_cs1_n", 32'(csn1), 32'h7);
    rst0 = 1'b0; rst1 = 1'b0;
    cyc(1);
    chk("ready_after_rst", 32'(b0.tx_ready), 1);

    // Mode 0, div=0, cs_sel=1, loopback, exact cycle timing
    b0.tx_data = 8'hA5; b0.tx_last = 1'b1; b0.tx_valid = 1'b1;
    q0.push_back(8'hA5);
    cyc(1);
    b0.tx_valid = 1'b0;
    chk("m0_T1_cs_n", 32'(csn0), 32'hD);
    chk("m0_T1_busy", 32'(busy0), 1);
    chk("m0_T1_mosi_msb", 32'(mosi0), 1);
    cyc(15);
    chk("m0_T16_no_rx", 32'(b0.rx_valid), 0);
    cyc(1);
    chk("m0_T17_rx_valid", 32'(b0.rx_valid), 1);
    chk("m0_T17_rx_data", 32'(b0.rx_data), 32'hA5);
    chk("m0_T17_sclk", 32'(clk0), 0);
    cyc(1);
    chk("m0_T18_cs_n", 32'(csn0), 32'hF);
    chk("m0_T18_ready", 32'(b0.tx_ready), 0);
    cyc(1);
    chk("m0_T19_ready", 32'(b0.tx_ready), 1);
    chk("m0_T19_busy", 32'(busy0), 0);

    // Modes 1..3, div=3, slave returns 0x3C
    loop0 = 1'b0;
    for (int m = 1; m < 4; m++) begin
      cpol0 = m[1]; cpha0 = m[0]; s_cpha = m[0]; div0 = 8'd3; sel0 = 2'd2;
      txw = 8'h96 ^ 8'(m);
      cyc(1);
      chk("mode_idle_sclk", 32'(clk0), 32'(m[1]));
      base = mosi_bad;
      send0(txw, 1'b1, 8'h3C);
      chk("mode_cs_n", 32'(csn0), 32'hB);
      wait_rx0(n);
      chk("mode_word_cycles", 32'(n), 64);
      wait_idle0();
      chk("mode_end_sclk", 32'(clk0), 32'(m[1]));
      chk("mode_mosi_word", 32'(sl_rx), 32'(txw));
      chk("mode_mosi_stable", 32'(mosi_bad - base), 0);
    end

    // Burst of three words in mode 2 with a 5-cycle gap before word 2
    loop0 = 1'b1; s_cpha = 1'b0;
    cpol0 = 1'b1; cpha0 = 1'b0; div0 = 8'd0; sel0 = 2'd1;
    cyc(1);
    rxb = rx_cnt0;
    base = cs_glitch;
    send0(8'h11, 1'b0, 8'h11);
    burst_mon = 1'b1;
    wait_rx0(n);
    chk("burst_w1_cycles", 32'(n), 16);
    cyc(5);
    chk("burst_wait_sclk", 32'(clk0), 1);
    chk("burst_wait_ready", 32'(b0.tx_ready), 1);
    chk("burst_wait_busy", 32'(busy0), 1);
    send0(8'h22, 1'b0, 8'h22);
    wait_rx0(n);
    send0(8'h33, 1'b1, 8'h33);
    wait_rx0(n);
    burst_mon = 1'b0;
    wait_idle0();
    chk("burst_cs_held", 32'(cs_glitch - base), 0);
    chk("burst_rx_pulses", 32'(rx_cnt0 - rxb), 3);

    // Config changes mid-burst are ignored until the next IDLE accept
    cpol0 = 1'b0; cpha0 = 1'b0; div0 = 8'd1; sel0 = 2'd2;
    cyc(1);
    send0(8'hC3, 1'b0, 8'hC3);
    cpol0 = 1'b1; cpha0 = 1'b1; div0 = 8'd0; sel0 = 2'd0;
    chk("cfg_w1_cs_n", 32'(csn0), 32'hB);
    wait_rx0(n);
    chk("cfg_w1_cycles", 32'(n), 32);
    send0(8'h5C, 1'b1, 8'h5C);
    chk("cfg_w2_cs_n", 32'(csn0), 32'hB);
    wait_rx0(n);
    chk("cfg_w2_cycles", 32'(n), 32);
    wait_idle0();
    cyc(1);
    chk("cfg_new_idle_sclk", 32'(clk0), 1);
    send0(8'hE7, 1'b1, 8'hE7);
    chk("cfg_new_cs_n", 32'(csn0), 32'hE);
    wait_rx0(n);
    chk("cfg_new_cycles", 32'(n), 16);
    wait_idle0();

    // cs_sel out of range on the 16-bit instance
    base = tog1;
    rxb  = cs1_low;
    b1.tx_data = 16'hBEEF; b1.tx_last = 1'b1; b1.tx_valid = 1'b1;
    q1.push_back(16'hBEEF);
    n = 0;
    while (b1.tx_ready !== 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    cyc(1);
    b1.tx_valid = 1'b0;
    n = 0;
    while (!(busy1 === 1'b0 && b1.tx_ready === 1'b1) && n < 2000) begin
      cyc(1);
      n++;
    end
    chk("cs_oor_idle", 32'(busy1), 0);
    chk("cs_oor_toggles", 32'(tog1 - base), 32);
    chk("cs_oor_no_cs", 32'(cs1_low - rxb), 0);
    chk("cs_oor_rx_pulses", 32'(rx_cnt1), 1);

    // Reset at toggle 7, then a fresh transfer
    cpol0 = 1'b0; cpha0 = 1'b0; div0 = 8'd1; sel0 = 2'd1;
    cyc(1);
    base = tog0;
    b0.tx_data = 8'hFF; b0.tx_last = 1'b1; b0.tx_valid = 1'b1;
    cyc(1);
    b0.tx_valid = 1'b0;
    n = 0;
    while ((tog0 - base) < 7 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("rst_mid_tog7", 32'(tog0 - base), 7);
    rxb = rx_cnt0;
    rst0 = 1'b1;
    cyc(1);
    chk("rst_mid_cs_n", 32'(csn0), 32'hF);
    chk("rst_mid_sclk", 32'(clk0), 0);
    chk("rst_mid_mosi", 32'(mosi0), 0);
    chk("rst_mid_ready", 32'(b0.tx_ready), 0);
    chk("rst_mid_rx_valid", 32'(b0.rx_valid), 0);
    chk("rst_mid_rx_data", 32'(b0.rx_data), 0);
    chk("rst_mid_busy", 32'(busy0), 0);
    rst0 = 1'b0;
    cyc(1);
    chk("rst_mid_ready_after", 32'(b0.tx_ready), 1);
    chk("rst_mid_no_rx", 32'(rx_cnt0 - rxb), 0);
    send0(8'h5A, 1'b1, 8'h5A);
    wait_rx0(n);
    chk("rst_fresh_cycles", 32'(n), 32);
    wait_idle0();

    cyc(2);
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
